// File: rtl/namco108_ext.sv
// Namco 108-family bank controller with run-time 206/076/088/154/095 variant select
// and an optional MMC3-style scanline IRQ counter driven by filtered PPU A12 edges.
module namco108_ext #(
  parameter int PRG_W   = 19,
  parameter int CHR_W   = 17,
  parameter int IRQ_EN  = 1,
  parameter int A12_LOW = 3
) (
  input  logic               m2,
  input  logic               rst_n,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_data,
  input  logic               cpu_rw,
  input  logic [13:0]        ppu_addr,
  input  logic [2:0]         mode,
  input  logic               mir_v,
  output logic [PRG_W-14:0]  prg_addr,
  output logic [CHR_W-11:0]  chr_addr,
  output logic               ciram_a10,
  output logic               irq
);

  localparam int B  = PRG_W - 13;
  localparam int C  = CHR_W - 10;
  localparam int LW = ($clog2(A12_LOW + 1) < 1) ? 1 : $clog2(A12_LOW + 1);

  logic [2:0]      sel_q, sel_d;
  logic [7:0][7:0] bank_q, bank_d;
  logic            mir1_q, mir1_d;
  logic [7:0]      latch_q, latch_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            reload_q, reload_d;
  logic            irqOn_q, irqOn_d;
  logic            pending_q, pending_d;
  logic [LW-1:0]   lowCnt_q, lowCnt_d;

  logic            wrEn;
  logic            a12;
  logic            edgeHit;
  logic [7:0]      newCnt;

  assign wrEn    = !cpu_rw && cpu_addr[15];
  assign a12     = ppu_addr[12];
  assign edgeHit = a12 && (lowCnt_q == LW'(A12_LOW));

  // The edge is evaluated on pre-write state; register writes are applied
  // afterwards so they override the counter update in the same cycle.
  always_comb begin
    sel_d     = sel_q;
    bank_d    = bank_q;
    mir1_d    = mir1_q;
    latch_d   = latch_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    irqOn_d   = irqOn_q;
    pending_d = pending_q;
    lowCnt_d  = lowCnt_q;
    newCnt    = cnt_q;

    if (a12) begin
      lowCnt_d = '0;
    end else if (lowCnt_q != LW'(A12_LOW)) begin
      lowCnt_d = lowCnt_q + LW'(1);
    end

    if ((IRQ_EN != 0) && edgeHit) begin
      if ((cnt_q == 8'd0) || reload_q) begin
        newCnt   = latch_q;
        reload_d = 1'b0;
      end else begin
        newCnt = cnt_q - 8'd1;
      end
      cnt_d = newCnt;
      if ((newCnt == 8'd0) && irqOn_q) begin
        pending_d = 1'b1;
      end
    end

    if (wrEn) begin
      if (mode == 3'd3) begin
        mir1_d = cpu_data[6];
      end
      if ((IRQ_EN == 0) || !cpu_addr[14]) begin
        if (!cpu_addr[0]) begin
          sel_d = cpu_data[2:0];
        end else begin
          bank_d[sel_q] = cpu_data;
        end
      end else begin
        case ({cpu_addr[13], cpu_addr[0]})
          2'b00: latch_d = cpu_data;
          2'b01: begin
            cnt_d    = 8'd0;
            reload_d = 1'b1;
          end
          2'b10: begin
            irqOn_d   = 1'b0;
            pending_d = 1'b0;
          end
          default: irqOn_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      bank_q    <= '0;
      mir1_q    <= 1'b0;
      latch_q   <= '0;
      cnt_q     <= '0;
      reload_q  <= 1'b0;
      irqOn_q   <= 1'b0;
      pending_q <= 1'b0;
      lowCnt_q  <= '0;
    end else begin
      sel_q     <= sel_d;
      bank_q    <= bank_d;
      mir1_q    <= mir1_d;
      latch_q   <= latch_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      irqOn_q   <= irqOn_d;
      pending_q <= pending_d;
      lowCnt_q  <= lowCnt_d;
    end
  end

  assign irq = pending_q;

  logic [7:0]  prgByte;
  logic [15:0] prgWide;

  always_comb begin
    case (cpu_addr[14:13])
      2'd0:    prgByte = bank_q[6];
      2'd1:    prgByte = bank_q[7];
      2'd2:    prgByte = 8'hFE;
      default: prgByte = 8'hFF;
    endcase
    prgWide  = {8'h00, prgByte};
    prg_addr = prgWide[B-1:0];
  end

  logic [7:0]  r0m, r1m, lowPair;
  logic [2:0]  idx1k, idx2k;
  logic [8:0]  chrFull;
  logic [15:0] chrWide;

  // 095 reuses R0/R1 bit 5 for nametable select, so those bits never reach CHR.
  always_comb begin
    r0m     = (mode == 3'd4) ? {3'b000, bank_q[0][4:0]} : bank_q[0];
    r1m     = (mode == 3'd4) ? {3'b000, bank_q[1][4:0]} : bank_q[1];
    lowPair = ppu_addr[11] ? r1m : r0m;
    idx1k   = 3'd2 + {1'b0, ppu_addr[11:10]};
    idx2k   = 3'd2 + {1'b0, ppu_addr[12:11]};
    if (mode == 3'd1) begin
      chrFull = {bank_q[idx2k], ppu_addr[10]};
    end else if (!a12) begin
      chrFull = {1'b0, lowPair[7:1], ppu_addr[10]};
    end else begin
      chrFull = {1'b0, bank_q[idx1k]};
    end
    chrWide  = {7'b0, chrFull};
    chr_addr = chrWide[C-1:0];
    if ((mode == 3'd2) || (mode == 3'd3)) begin
      chr_addr[C-1] = a12;
    end
  end

  always_comb begin
    case (mode)
      3'd3:    ciram_a10 = mir1_q;
      3'd4:    ciram_a10 = ppu_addr[11] ? bank_q[1][5] : bank_q[0][5];
      default: ciram_a10 = mir_v ? ppu_addr[10] : ppu_addr[11];
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{cpu_addr[12:1], ppu_addr[13], ppu_addr[9:0], bank_q, prgWide, chrWide};

endmodule

// File: tb/tb_namco108_ext.sv
// Directed bench for namco108_ext: PRG/CHR banking per variant, mirroring and
// scanline IRQ behaviour including filter, write/edge collisions and async reset.
module tb_namco108_ext;

  logic        m2;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_rw;
  logic [13:0] ppu_addr;
  logic [2:0]  mode;
  logic        mir_v;
  logic [5:0]  prg_addr;
  logic [6:0]  chr_addr;
  logic        ciram_a10;
  logic        irq;

  int checkCount = 0;
  int passCount  = 0;

  namco108_ext #(
    .PRG_W(19), .CHR_W(17), .IRQ_EN(1), .A12_LOW(3)
  ) dut (
    .m2(m2), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rw(cpu_rw), .ppu_addr(ppu_addr), .mode(mode), .mir_v(mir_v),
    .prg_addr(prg_addr), .chr_addr(chr_addr), .ciram_a10(ciram_a10), .irq(irq)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  task automatic cpuWrite(input logic [15:0] a, input logic [7:0] d);
    @(posedge m2); #1;
    cpu_addr = a; cpu_data = d; cpu_rw = 1'b0;
    @(negedge m2); #1;
    cpu_rw = 1'b1;
  endtask

  task automatic a12Cycle(input logic v);
    @(posedge m2); #1;
    ppu_addr = v ? 14'h1000 : 14'h0000;
    @(negedge m2); #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #17;
    @(posedge m2); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mode = 3'd0; mir_v = 1'b1; ppu_addr = 14'h0000;
    doReset();
    cpu_addr = 16'h8000; #1;
    checkCount++; if (prg_addr !== 6'h00) $display("[TB] FAIL rst_prg8000 got %0h want 0", prg_addr); else passCount++;
    cpu_addr = 16'hA000; #1;
    checkCount++; if (prg_addr !== 6'h00) $display("[TB] FAIL rst_prgA000 got %0h want 0", prg_addr); else passCount++;
    cpu_addr = 16'hE000; #1;
    checkCount++; if (prg_addr !== 6'h3F) $display("[TB] FAIL rst_prgE000 got %0h want 3f", prg_addr); else passCount++;
    checkCount++; if (irq !== 1'b0) $display("[TB] FAIL rst_irq got %0b want 0", irq); else passCount++;
    ppu_addr = 14'h0400; #1;
    checkCount++; if (ciram_a10 !== 1'b1) $display("[TB] FAIL rst_ciram_v got %0b want 1", ciram_a10); else passCount++;
    mir_v = 1'b0; #1;
    checkCount++; if (ciram_a10 !== 1'b0) $display("[TB] FAIL rst_ciram_h got %0b want 0", ciram_a10); else passCount++;
    checkCount++; if (chr_addr !== 7'h01) $display("[TB] FAIL rst_chr got %0h want 1", chr_addr); else passCount++;
  endtask

  task automatic test_prg();
    cpuWrite(16'h8000, 8'h06); cpuWrite(16'h8001, 8'h05);
    cpuWrite(16'h8000, 8'h07); cpuWrite(16'h8001, 8'h3F);
    cpu_addr = 16'h8000; #1;
    checkCount++; if (prg_addr !== 6'h05) $display("[TB] FAIL prg8000 got %0h want 5", prg_addr); else passCount++;
    cpu_addr = 16'hA000; #1;
    checkCount++; if (prg_addr !== 6'h3F) $display("[TB] FAIL prgA000 got %0h want 3f", prg_addr); else passCount++;
    cpu_addr = 16'hC000; #1;
    checkCount++; if (prg_addr !== 6'h3E) $display("[TB] FAIL prgC000 got %0h want 3e", prg_addr); else passCount++;
    cpu_addr = 16'hE000; #1;
    checkCount++; if (prg_addr !== 6'h3F) $display("[TB] FAIL prgE000 got %0h want 3f", prg_addr); else passCount++;
  endtask

  task automatic test_chr();
    mode = 3'd0;
    cpuWrite(16'h8000, 8'h01); cpuWrite(16'h8001, 8'h0B);
    cpuWrite(16'h8000, 8'h02); cpuWrite(16'h8001, 8'h01);
    cpuWrite(16'h8000, 8'h03); cpuWrite(16'h8001, 8'h02);
    cpuWrite(16'h8000, 8'h04); cpuWrite(16'h8001, 8'h03);
    cpuWrite(16'h8000, 8'h05); cpuWrite(16'h8001, 8'h04);
    ppu_addr = 14'h0800; #1;
    checkCount++; if (chr_addr !== 7'h0A) $display("[TB] FAIL chr206_0800 got %0h want a", chr_addr); else passCount++;
    ppu_addr = 14'h0C00; #1;
    checkCount++; if (chr_addr !== 7'h0B) $display("[TB] FAIL chr206_0C00 got %0h want b", chr_addr); else passCount++;
    ppu_addr = 14'h1800; #1;
    checkCount++; if (chr_addr !== 7'h03) $display("[TB] FAIL chr206_1800 got %0h want 3", chr_addr); else passCount++;
    mode = 3'd1;
    ppu_addr = 14'h0400; #1;
    checkCount++; if (chr_addr !== 7'h03) $display("[TB] FAIL chr076_0400 got %0h want 3", chr_addr); else passCount++;
    ppu_addr = 14'h1C00; #1;
    checkCount++; if (chr_addr !== 7'h09) $display("[TB] FAIL chr076_1C00 got %0h want 9", chr_addr); else passCount++;
  endtask

  task automatic test_mode4();
    mode = 3'd4;
    cpuWrite(16'h8000, 8'h00); cpuWrite(16'h8001, 8'hEB);
    ppu_addr = 14'h0000; #1;
    checkCount++; if (chr_addr !== 7'h0A) $display("[TB] FAIL chr095_mask got %0h want a", chr_addr); else passCount++;
    checkCount++; if (ciram_a10 !== 1'b1) $display("[TB] FAIL nt095_r0 got %0b want 1", ciram_a10); else passCount++;
    ppu_addr = 14'h0800; #1;
    checkCount++; if (ciram_a10 !== 1'b0) $display("[TB] FAIL nt095_r1 got %0b want 0", ciram_a10); else passCount++;
  endtask

  task automatic test_mode3();
    mode = 3'd2; ppu_addr = 14'h0000; #1;
    checkCount++; if (chr_addr !== 7'h2A) $display("[TB] FAIL chr088_msb got %0h want 2a", chr_addr); else passCount++;
    mode = 3'd3; mir_v = 1'b0;
    cpuWrite(16'h8000, 8'h40);
    checkCount++; if (ciram_a10 !== 1'b1) $display("[TB] FAIL nt154_h got %0b want 1", ciram_a10); else passCount++;
    mir_v = 1'b1; #1;
    checkCount++; if (ciram_a10 !== 1'b1) $display("[TB] FAIL nt154_v got %0b want 1", ciram_a10); else passCount++;
    cpuWrite(16'h8000, 8'h00);
    ppu_addr = 14'h0400; #1;
    checkCount++; if (ciram_a10 !== 1'b0) $display("[TB] FAIL nt154_clr got %0b want 0", ciram_a10); else passCount++;
    ppu_addr = 14'h1000; #1;
    checkCount++; if (chr_addr !== 7'h41) $display("[TB] FAIL chr154_msb got %0h want 41", chr_addr); else passCount++;
  endtask

  task automatic test_irq();
    mode = 3'd0; ppu_addr = 14'h0000;
    doReset();
    cpuWrite(16'hC000, 8'h02); cpuWrite(16'hC001, 8'h00); cpuWrite(16'hE001, 8'h00);
    for (int e = 1; e <= 3; e++) begin
      a12Cycle(1'b0); a12Cycle(1'b0); a12Cycle(1'b0);
      checkCount++; if (irq !== 1'b0) $display("[TB] FAIL irq_pre_edge%0d got %0b want 0", e, irq); else passCount++;
      a12Cycle(1'b1);
      checkCount++;
      if (irq !== (e == 3)) $display("[TB] FAIL irq_edge%0d got %0b want %0b", e, irq, (e == 3)); else passCount++;
    end
    ppu_addr = 14'h0000;
    cpuWrite(16'hE000, 8'h00);
    checkCount++; if (irq !== 1'b0) $display("[TB] FAIL irq_ack got %0b want 0", irq); else passCount++;
  endtask

  task automatic test_filter();
    cpuWrite(16'hC000, 8'h00);
    a12Cycle(1'b1);
    a12Cycle(1'b0);
    cpuWrite(16'hE001, 8'h00);
    a12Cycle(1'b1);
    checkCount++; if (irq !== 1'b0) $display("[TB] FAIL filter_short got %0b want 0", irq); else passCount++;
    a12Cycle(1'b0); a12Cycle(1'b0); a12Cycle(1'b0); a12Cycle(1'b1);
    checkCount++; if (irq !== 1'b1) $display("[TB] FAIL latch0_edge got %0b want 1", irq); else passCount++;
  endtask

  task automatic test_back_to_back();
    a12Cycle(1'b0);
    cpuWrite(16'hE000, 8'h00);
    cpuWrite(16'hE001, 8'h00);
    a12Cycle(1'b0);
    @(posedge m2); #1;
    ppu_addr = 14'h1000; cpu_addr = 16'hE000; cpu_rw = 1'b0;
    @(negedge m2); #1;
    cpu_rw = 1'b1;
    checkCount++; if (irq !== 1'b0) $display("[TB] FAIL ack_vs_edge got %0b want 0", irq); else passCount++;
  endtask

  task automatic test_async_reset();
    cpuWrite(16'h8000, 8'h06); cpuWrite(16'h8001, 8'h05);
    cpuWrite(16'h8000, 8'h02); cpuWrite(16'h8001, 8'h07);
    cpuWrite(16'hE001, 8'h00);
    a12Cycle(1'b0); a12Cycle(1'b0); a12Cycle(1'b0); a12Cycle(1'b1);
    cpu_addr = 16'h8000; #1;
    checkCount++; if (irq !== 1'b1) $display("[TB] FAIL pre_rst_irq got %0b want 1", irq); else passCount++;
    checkCount++; if (prg_addr !== 6'h05) $display("[TB] FAIL pre_rst_prg got %0h want 5", prg_addr); else passCount++;
    checkCount++; if (chr_addr !== 7'h07) $display("[TB] FAIL pre_rst_chr got %0h want 7", chr_addr); else passCount++;
    @(posedge m2); #2;
    rst_n = 1'b0; #1;
    checkCount++; if (irq !== 1'b0) $display("[TB] FAIL async_irq got %0b want 0", irq); else passCount++;
    checkCount++; if (prg_addr !== 6'h00) $display("[TB] FAIL async_prg got %0h want 0", prg_addr); else passCount++;
    checkCount++; if (chr_addr !== 7'h00) $display("[TB] FAIL async_chr got %0h want 0", chr_addr); else passCount++;
    @(posedge m2); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cpu_addr = 16'h0000; cpu_data = 8'h00; cpu_rw = 1'b1;
    ppu_addr = 14'h0000; mode = 3'd0; mir_v = 1'b0;
    test_reset();
    test_prg();
    test_chr();
    test_mode4();
    test_mode3();
    test_irq();
    test_filter();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
